and_gate: RTL and testbench
===========================

# and_gate

Bitwise two-input AND primitive for the gate-level library, with an optional registered copy of the result for pipelined datapaths. The combinational output `out` is the basic building block for higher gates (Mux, And16, ALU). The registered side (`out_q`, flags, `out_valid`) lets sequential blocks consume a clean, reset-defined AND result one cycle later.

## Interface

- Clock/reset: one clock; reset is synchronous and active-high (ports `clk`, `reset`).
- `WIDTH`, default 1: operand and result width in bits, legal range 1..64.
- `clk`  input  1  rising-edge clock for all registered outputs.
- `reset`  input  1  synchronous, active-high; clears all registers.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `in_valid`  input  1  qualifies `a`/`b` for the registered path.
- `out`  output  WIDTH  combinational `a & b`, bit by bit.
- `out_q`  output  WIDTH  registered `a & b`, captured when `in_valid` is high.
- `out_valid`  output  1  high for one cycle after each accepted `in_valid`.
- `all_ones`  output  1  registered; high when the captured result has every bit set.
- `any_one`  output  1  registered; high when the captured result has at least one bit set.

## Operation

- `out[i] = a[i] & b[i]` for every i.
  - Pure combinational logic with no dependence on `clk`, `reset` or `in_valid`.
  - Valid whenever the inputs are stable, including while `reset` is high.
- Truth table per bit: 0&0=0, 0&1=0, 1&0=0, 1&1=1.
- X/Z handling follows standard 4-state `&` semantics; nothing is masked.
- Registered path, on each rising `clk`:
  - `reset`=1: `out_q`←0, `out_valid`←0, `all_ones`←0, `any_one`←0.
  - Else if `in_valid`=1: `out_q`←`a&b`, `all_ones`←&(`a&b`), `any_one`←|(`a&b`), `out_valid`←1.
  - Else: `out_q`, `all_ones` and `any_one` hold their values; `out_valid`←0.
- `reset` takes priority over `in_valid` in the same cycle; the input is dropped.
- No backpressure: every valid input is accepted, so throughput is one result per cycle.
- Back-to-back `in_valid` keeps `out_valid` high continuously.

## Timing

- `out`: zero-cycle combinational latency; settles within one gate delay of any change on `a` or `b`.
- `out_q`, flags and `out_valid`: latency is 1 clock from the edge that samples `in_valid`=1.
- Reset values: `out_q`=0, `out_valid`=0, `all_ones`=0, `any_one`=0. `out` has no reset value; it always equals `a&b`.
- When `reset` is deasserted, the first capture can happen on the next rising edge that sees `in_valid`=1.
- Asserting `reset` in the middle of a stream clears all registered outputs on the next edge; `out` is unaffected.

## Test plan

- WIDTH=1, no clock activity: apply (a,b) = (0,0), (0,1), (1,0), (1,1), waiting 1 time unit after each. Required `out` = 0, 0, 0, 1.
- WIDTH=8, a=8'hF0, b=8'h3C, `in_valid` held for one cycle:
  - `out`=8'h30 immediately.
  - One cycle later: `out_q`=8'h30, `any_one`=1, `all_ones`=0, `out_valid` high for exactly one cycle.
- WIDTH=8, a=b=8'hFF, `in_valid`=1 → `out_q`=8'hFF and `all_ones`=1. Then `in_valid`=0 with a=0 → `out`=0 while `out_q` holds 8'hFF.
- Reset: after any capture, drive `reset`=1 and `in_valid`=1 together for one edge. Required: `out_q`=0, `out_valid`=0, both flags 0, while `out` still equals `a&b`.
- Streaming: drive `in_valid`=1 for 4 consecutive cycles with a = 1, 2, 3, 4 and b=8'h03. Required: `out_valid` stays high for 4 cycles and `out_q` sequence = 1, 2, 3, 0.

Source files
------------

// File: rtl/and_gate.sv
// Bitwise two-input AND with a registered copy of the result, plus
// all-ones / any-one flags and a one-cycle valid strobe for pipelined consumers.
module and_gate #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one
);

  logic [WIDTH-1:0] andResult;

  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic             valid_q;
  logic             valid_d;
  logic             allOnes_q;
  logic             allOnes_d;
  logic             anyOne_q;
  logic             anyOne_d;

  assign andResult = a & b;
  assign out       = andResult;

  // Captured values hold between accepted inputs; only the valid strobe drops.
  always_comb begin
    result_d  = result_q;
    allOnes_d = allOnes_q;
    anyOne_d  = anyOne_q;
    valid_d   = 1'b0;
    if (in_valid) begin
      result_d  = andResult;
      allOnes_d = &andResult;
      anyOne_d  = |andResult;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q  <= '0;
      valid_q   <= 1'b0;
      allOnes_q <= 1'b0;
      anyOne_q  <= 1'b0;
    end else begin
      result_q  <= result_d;
      valid_q   <= valid_d;
      allOnes_q <= allOnes_d;
      anyOne_q  <= anyOne_d;
    end
  end

  assign out_q     = result_q;
  assign out_valid = valid_q;
  assign all_ones  = allOnes_q;
  assign any_one   = anyOne_q;

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: an 8-bit instance checked every cycle
// against a behavioural model, a 1-bit instance for the truth table, plus directed literals.
module tb_and_gate;

  logic       clk;
  logic       reset;
  logic [7:0] a;
  logic [7:0] b;
  logic       inValid;
  logic [7:0] out;
  logic [7:0] outQ;
  logic       outValid;
  logic       allOnes;
  logic       anyOne;

  logic       a1;
  logic       b1;
  logic       inValid1;
  logic       out1;
  logic       outQ1;
  logic       outValid1;
  logic       allOnes1;
  logic       anyOne1;

  int checkCount = 0;
  int passCount  = 0;
  bit compareOn  = 0;

  // Model state: last product accepted since reset, and whether the previous edge accepted one.
  logic [7:0] modelHeld;
  bit         modelStrobe;

  and_gate #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a        (a),
    .b        (b),
    .in_valid (inValid),
    .out      (out),
    .out_q    (outQ),
    .out_valid(outValid),
    .all_ones (allOnes),
    .any_one  (anyOne)
  );

  and_gate #(.WIDTH(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .a        (a1),
    .b        (b1),
    .in_valid (inValid1),
    .out      (out1),
    .out_q    (outQ1),
    .out_valid(outValid1),
    .all_ones (allOnes1),
    .any_one  (anyOne1)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic v, input logic r);
    a       = av;
    b       = bv;
    inValid = v;
    reset   = r;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      modelHeld   <= 8'h00;
      modelStrobe <= 1'b0;
    end else begin
      modelStrobe <= inValid;
      if (inValid) modelHeld <= a & b;
    end
  end

  // Compare every cycle, mid-period, once reset has defined the registers.
  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("model out",       {56'd0, out},      {56'd0, a & b});
      checkOutput("model out_q",     {56'd0, outQ},     {56'd0, modelHeld});
      checkOutput("model out_valid", {63'd0, outValid}, {63'd0, modelStrobe});
      checkOutput("model all_ones",  {63'd0, allOnes},  {63'd0, modelHeld == 8'hFF});
      checkOutput("model any_one",   {63'd0, anyOne},   {63'd0, modelHeld != 8'h00});
      checkOutput("model out w1",    {63'd0, out1},     {63'd0, a1 & b1});
    end
  end

  initial begin
    logic [7:0] streamExp [4];
    logic       truthExp  [4];
    streamExp = '{8'h01, 8'h02, 8'h03, 8'h00};
    truthExp  = '{1'b0, 1'b0, 1'b0, 1'b1};

    inValid1 = 0;
    a1 = 0;
    b1 = 0;
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b1);

    // Truth table on the 1-bit instance, no dependence on the clock.
    for (int i = 0; i < 4; i++) begin
      a1 = i[1];
      b1 = i[0];
      #1;
      checkOutput("truth table", {63'd0, out1}, {63'd0, truthExp[i]});
    end

    nextEdge();
    nextEdge();
    checkOutput("reset out_q",     {56'd0, outQ},     64'd0);
    checkOutput("reset out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset all_ones",  {63'd0, allOnes},  64'd0);
    checkOutput("reset any_one",   {63'd0, anyOne},   64'd0);
    checkOutput("reset w1 out_q",  {63'd0, outQ1},    64'd0);
    compareOn = 1;

    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    nextEdge();
    applyStimulus(8'hF0, 8'h3C, 1'b1, 1'b0);
    #1;
    checkOutput("F0&3C out", {56'd0, out}, 64'h30);
    nextEdge();
    checkOutput("F0&3C out_q",     {56'd0, outQ},     64'h30);
    checkOutput("F0&3C any_one",   {63'd0, anyOne},   64'd1);
    checkOutput("F0&3C all_ones",  {63'd0, allOnes},  64'd0);
    checkOutput("F0&3C out_valid", {63'd0, outValid}, 64'd1);
    applyStimulus(8'hF0, 8'h3C, 1'b0, 1'b0);
    nextEdge();
    checkOutput("F0&3C valid drop", {63'd0, outValid}, 64'd0);
    checkOutput("F0&3C hold",       {56'd0, outQ},     64'h30);

    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0);
    nextEdge();
    checkOutput("FF out_q",    {56'd0, outQ},    64'hFF);
    checkOutput("FF all_ones", {63'd0, allOnes}, 64'd1);
    applyStimulus(8'h00, 8'hFF, 1'b0, 1'b0);
    #1;
    checkOutput("a=0 out", {56'd0, out}, 64'h00);
    nextEdge();
    checkOutput("FF hold out_q",    {56'd0, outQ},    64'hFF);
    checkOutput("FF hold all_ones", {63'd0, allOnes}, 64'd1);

    // Reset wins over a simultaneous valid input.
    applyStimulus(8'hA5, 8'h0F, 1'b1, 1'b1);
    nextEdge();
    checkOutput("rst+valid out_q",     {56'd0, outQ},     64'd0);
    checkOutput("rst+valid out_valid", {63'd0, outValid}, 64'd0);
    checkOutput("rst+valid all_ones",  {63'd0, allOnes},  64'd0);
    checkOutput("rst+valid any_one",   {63'd0, anyOne},   64'd0);
    checkOutput("rst+valid out",       {56'd0, out},      64'h05);

    applyStimulus(8'h01, 8'h03, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nextEdge();
      checkOutput("stream out_q",     {56'd0, outQ},     {56'd0, streamExp[i]});
      checkOutput("stream out_valid", {63'd0, outValid}, 64'd1);
      if (i < 3) applyStimulus(8'(i + 2), 8'h03, 1'b1, 1'b0);
      else       applyStimulus(8'h00, 8'h03, 1'b0, 1'b0);
    end
    nextEdge();
    checkOutput("stream end valid", {63'd0, outValid}, 64'd0);
    checkOutput("stream end hold",  {56'd0, outQ},     64'h00);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'($urandom), 8'($urandom), 1'($urandom), 1'(i == 7));
      a1 = 1'($urandom);
      b1 = 1'($urandom);
      nextEdge();
    end
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
    nextEdge();
    nextEdge();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
